// File: rtl/gc_sequencer.sv
// rtl/gc_sequencer.sv - global-control sequencer: exception select, drain/flush/discard ordering, PC override.
// Optional SFENCE/TLB_CLEAR path compiled in when GC_SFENCE_EN is defined.
module gc_sequencer #(
    parameter int          NUM_SRC     = 4,
    parameter int          ID_W        = 3,
    parameter int          CLEAR_DEPTH = 64,
    parameter int          TLB_DEPTH   = 32,
    parameter logic [31:0] RESET_VEC   = 32'h80000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    is_ifence,
    input  logic                    is_sfence,
    input  logic                    is_ret,
    input  logic [31:0]             pc_p4,
    output logic                    issue_ready,
    input  logic [NUM_SRC-1:0]      exc_valid,
    input  logic [NUM_SRC*ID_W-1:0] exc_id,
    input  logic [NUM_SRC*5-1:0]    exc_code,
    input  logic [NUM_SRC*32-1:0]   exc_tval,
    output logic [NUM_SRC-1:0]      exc_ack,
    input  logic [ID_W-1:0]         oldest_id,
    input  logic                    interrupt_pending,
    output logic                    interrupt_taken,
    input  logic [31:0]             trap_target_pc,
    input  logic [31:0]             epc,
    input  logic [ID_W:0]           post_issue_count,
    input  logic                    sq_empty,
    input  logic                    no_released_stores_pending,
    output logic                    trap_valid,
    output logic [4:0]              trap_code,
    output logic [31:0]             trap_tval,
    output logic                    ret_taken,
    output logic                    fetch_hold,
    output logic                    issue_hold,
    output logic                    retire_hold,
    output logic                    writeback_supress,
    output logic                    init_clear,
    output logic                    tlb_flush,
    output logic                    sq_flush,
    output logic                    pc_override,
    output logic [31:0]             pc_out
);

    localparam int MAX_DEPTH = (CLEAR_DEPTH > TLB_DEPTH) ? CLEAR_DEPTH : TLB_DEPTH;
    localparam int CNT_W     = $clog2(MAX_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT_CLEAR,
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DISCARD,
        ST_TLB_CLEAR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               op_pending;
    logic               op_ret;
    logic [31:0]        op_pc;
`ifdef GC_SFENCE_EN
    logic               op_sfence;
    logic               cause_sfence;
`endif

    logic               sel_found;
    logic [NUM_SRC-1:0] sel_onehot;
    logic [4:0]         sel_code;
    logic [31:0]        sel_tval;
    logic               accept;
    logic               any_exc;
    logic               drained;
    logic               take_trap;
    logic               take_op;
    logic               take_int;
    logic               enter_flush;
    logic               init_done;

    // Oldest-instruction exception: lowest source index whose ID matches the oldest in flight.
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_code   = '0;
        sel_tval   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!sel_found && exc_valid[i] && (exc_id[i*ID_W +: ID_W] == oldest_id)) begin
                sel_found     = 1'b1;
                sel_onehot[i] = 1'b1;
                sel_code      = exc_code[i*5 +: 5];
                sel_tval      = exc_tval[i*32 +: 32];
            end
        end
    end

    assign issue_ready = ~rst & (state == ST_IDLE) & ~op_pending;
    assign accept      = issue_valid & issue_ready;
    assign any_exc     = |exc_valid;
    assign drained     = (post_issue_count == '0);
    assign init_done   = (cnt == CNT_W'(CLEAR_DEPTH - 1));

    always_comb begin
        next_state = state;
        take_trap  = 1'b0;
        take_op    = 1'b0;
        take_int   = 1'b0;
        case (state)
            ST_RESET: next_state = ST_INIT_CLEAR;
            ST_INIT_CLEAR: begin
                if (init_done)
                    next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (sel_found) begin
                    next_state = ST_FLUSH;
                    take_trap  = 1'b1;
                end else if (accept || interrupt_pending || any_exc) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sel_found) begin
                    next_state = ST_FLUSH;
                    take_trap  = 1'b1;
                end else if (op_pending && drained && sq_empty) begin
                    next_state = ST_FLUSH;
                    take_op    = 1'b1;
                end else if (interrupt_pending && !op_pending) begin
                    next_state = ST_FLUSH;
                    take_int   = 1'b1;
                end else if (!op_pending && !interrupt_pending && !any_exc) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FLUSH: next_state = ST_DISCARD;
            ST_DISCARD: begin
                if (drained && no_released_stores_pending) begin
`ifdef GC_SFENCE_EN
                    next_state = cause_sfence ? ST_TLB_CLEAR : ST_IDLE;
`else
                    next_state = ST_IDLE;
`endif
                end
            end
            ST_TLB_CLEAR: begin
`ifdef GC_SFENCE_EN
                if (cnt == CNT_W'(TLB_DEPTH - 1))
                    next_state = ST_IDLE;
`else
                next_state = ST_IDLE;
`endif
            end
            default: next_state = ST_RESET;
        endcase
    end

    assign enter_flush     = (next_state == ST_FLUSH);
    assign trap_valid      = ~rst & take_trap;
    assign exc_ack         = trap_valid ? sel_onehot : '0;
    assign trap_code       = trap_valid ? sel_code : 5'd0;
    assign trap_tval       = trap_valid ? sel_tval : 32'd0;
    assign interrupt_taken = ~rst & take_int;
    assign ret_taken       = ~rst & take_op & op_ret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_RESET;
            cnt               <= '0;
            op_pending        <= 1'b0;
            op_ret            <= 1'b0;
            op_pc             <= '0;
`ifdef GC_SFENCE_EN
            op_sfence         <= 1'b0;
            cause_sfence      <= 1'b0;
`endif
            pc_out            <= '0;
            fetch_hold        <= 1'b0;
            issue_hold        <= 1'b0;
            retire_hold       <= 1'b0;
            writeback_supress <= 1'b0;
            init_clear        <= 1'b0;
            tlb_flush         <= 1'b0;
            sq_flush          <= 1'b0;
            pc_override       <= 1'b0;
        end else begin
            state <= next_state;

            if (state == ST_INIT_CLEAR || state == ST_TLB_CLEAR)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            // A trap taken while an op is still draining discards that op.
            if (enter_flush) begin
                op_pending <= 1'b0;
            end else if (accept) begin
                op_pending <= 1'b1;
                op_ret     <= is_ret & ~(is_ifence | is_sfence);
                op_pc      <= pc_p4;
`ifdef GC_SFENCE_EN
                op_sfence  <= is_sfence;
`endif
            end

`ifdef GC_SFENCE_EN
            if (enter_flush)
                cause_sfence <= take_op & op_sfence;
`endif

            if (take_trap || take_int)
                pc_out <= trap_target_pc;
            else if (take_op)
                pc_out <= op_ret ? epc : op_pc;
            else if (state == ST_INIT_CLEAR && next_state == ST_IDLE)
                pc_out <= RESET_VEC;

            fetch_hold        <= next_state inside {ST_INIT_CLEAR, ST_DRAIN, ST_FLUSH};
            issue_hold        <= next_state inside {ST_INIT_CLEAR, ST_DRAIN, ST_FLUSH,
                                                    ST_DISCARD, ST_TLB_CLEAR};
            writeback_supress <= next_state inside {ST_INIT_CLEAR, ST_DISCARD};
            retire_hold       <= (next_state == ST_FLUSH);
            init_clear        <= (next_state == ST_INIT_CLEAR);
`ifdef GC_SFENCE_EN
            tlb_flush         <= next_state inside {ST_INIT_CLEAR, ST_TLB_CLEAR};
`else
            tlb_flush         <= 1'b0;
`endif
            sq_flush          <= (state == ST_DISCARD) && (next_state != ST_DISCARD);
            pc_override       <= enter_flush || (state == ST_INIT_CLEAR && next_state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_gc_sequencer.sv
// tb/tb_gc_sequencer.sv - randomized scoreboard bench for gc_sequencer (expected event stream vs observed).
module tb_gc_sequencer;

`ifdef GC_SFENCE_EN
    localparam bit SFENCE_EN = 1'b1;
`else
    localparam bit SFENCE_EN = 1'b0;
`endif
    localparam int          NSRC   = 4;
    localparam int          IDW    = 3;
    localparam int          CLR_D  = 64;
    localparam int          TLB_D  = 32;
    localparam logic [31:0] RVEC   = 32'h80000000;

    localparam int K_TRAP = 0, K_RET = 1, K_INT = 2, K_PC = 3, K_SQ = 4, K_TLB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic issue_valid = 0, is_ifence = 0, is_sfence = 0, is_ret = 0;
    logic [31:0] pc_p4 = 0;
    logic issue_ready;
    logic [NSRC-1:0] exc_valid = 0;
    logic [NSRC*IDW-1:0] exc_id = 0;
    logic [NSRC*5-1:0] exc_code = 0;
    logic [NSRC*32-1:0] exc_tval = 0;
    logic [NSRC-1:0] exc_ack;
    logic [IDW-1:0] oldest_id = 0;
    logic interrupt_pending = 0, interrupt_taken;
    logic [31:0] trap_target_pc = 0, epc = 0;
    logic [IDW:0] post_issue_count = 0;
    logic sq_empty = 1, no_released_stores_pending = 1;
    logic trap_valid;
    logic [4:0] trap_code;
    logic [31:0] trap_tval;
    logic ret_taken;
    logic fetch_hold, issue_hold, retire_hold, writeback_supress, init_clear, tlb_flush, sq_flush, pc_override;
    logic [31:0] pc_out;

    gc_sequencer #(.NUM_SRC(NSRC), .ID_W(IDW), .CLEAR_DEPTH(CLR_D), .TLB_DEPTH(TLB_D), .RESET_VEC(RVEC)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .is_ifence(is_ifence), .is_sfence(is_sfence),
        .is_ret(is_ret), .pc_p4(pc_p4), .issue_ready(issue_ready), .exc_valid(exc_valid), .exc_id(exc_id),
        .exc_code(exc_code), .exc_tval(exc_tval), .exc_ack(exc_ack), .oldest_id(oldest_id),
        .interrupt_pending(interrupt_pending), .interrupt_taken(interrupt_taken),
        .trap_target_pc(trap_target_pc), .epc(epc), .post_issue_count(post_issue_count),
        .sq_empty(sq_empty), .no_released_stores_pending(no_released_stores_pending),
        .trap_valid(trap_valid), .trap_code(trap_code), .trap_tval(trap_tval), .ret_taken(ret_taken),
        .fetch_hold(fetch_hold), .issue_hold(issue_hold), .retire_hold(retire_hold),
        .writeback_supress(writeback_supress), .init_clear(init_clear), .tlb_flush(tlb_flush),
        .sq_flush(sq_flush), .pc_override(pc_override), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [3:0]  ack;
        logic [4:0]  code;
        logic [31:0] tval;
        int          len;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  tlb_run = 0;

    function automatic string kname(input int k);
        case (k)
            K_TRAP: return "trap";
            K_RET:  return "ret";
            K_INT:  return "interrupt";
            K_PC:   return "pc_override";
            K_SQ:   return "sq_flush";
            default: return "tlb_flush_run";
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] pc, input logic [3:0] ack,
                        input logic [4:0] code, input logic [31:0] tval, input int len);
        ev_t e;
        e.kind = kind; e.pc = pc; e.ack = ack; e.code = code; e.tval = tval; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] pc, input logic [3:0] ack,
                           input logic [4:0] code, input logic [31:0] tval, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s actual=observed required=none (t=%0t)", kname(kind), $time);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            failures++;
            $display("FAIL event_order actual=%s required=%s (t=%0t)", kname(kind), kname(e.kind), $time);
        end else if (kind == K_TRAP && (ack !== e.ack || code !== e.code || tval !== e.tval)) begin
            failures++;
            $display("FAIL trap_fields actual=ack %b code %0d tval %h required=ack %b code %0d tval %h",
                     ack, code, tval, e.ack, e.code, e.tval);
        end else if (kind == K_PC && pc !== e.pc) begin
            failures++;
            $display("FAIL pc_out actual=%h required=%h", pc, e.pc);
        end else if (kind == K_TLB && len != e.len) begin
            failures++;
            $display("FAIL tlb_flush_len actual=%0d required=%0d", len, e.len);
        end
    endtask

    // Monitor: every output event is popped against the expected stream in a fixed per-cycle order.
    always @(negedge clk) begin
        if (rst) begin
            tlb_run <= 0;
        end else begin
            if (trap_valid)      observe(K_TRAP, 32'h0, exc_ack, trap_code, trap_tval, 0);
            if (ret_taken)       observe(K_RET, 32'h0, 4'h0, 5'h0, 32'h0, 0);
            if (interrupt_taken) observe(K_INT, 32'h0, 4'h0, 5'h0, 32'h0, 0);
            if (pc_override)     observe(K_PC, pc_out, 4'h0, 5'h0, 32'h0, 0);
            if (sq_flush)        observe(K_SQ, 32'h0, 4'h0, 5'h0, 32'h0, 0);
            if (tlb_flush) begin
                tlb_run <= tlb_run + 1;
            end else if (tlb_run != 0) begin
                observe(K_TLB, 32'h0, 4'h0, 5'h0, 32'h0, tlb_run);
                tlb_run <= 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(issue_ready && exp_q.size() == 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_return_idle"}, 64'(n < 600), 64'd1);
        tick;
        check({name, "_events_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic set_defaults;
        issue_valid = 0; is_ifence = 0; is_sfence = 0; is_ret = 0;
        exc_valid = 0; interrupt_pending = 0;
        post_issue_count = 0; sq_empty = 1; no_released_stores_pending = 1;
    endtask

    task automatic reset_and_init;
        int n, len, first;
        rst = 1;
        set_defaults();
        repeat (3) tick;
        check("reset_controls",
              64'({fetch_hold, issue_hold, retire_hold, writeback_supress, init_clear, tlb_flush,
                   sq_flush, pc_override, issue_ready, trap_valid, interrupt_taken, ret_taken, exc_ack}), 64'd0);
        check("reset_pc_out", 64'(pc_out), 64'd0);
        exp_q.delete();
        push(K_PC, RVEC, 0, 0, 0, 0);
        if (SFENCE_EN) push(K_TLB, 0, 0, 0, 0, CLR_D);
        rst = 0;
        n = 0; len = 0; first = -1;
        while (!issue_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (init_clear) begin
                len++;
                if (first < 0) first = n;
            end
        end
        check("init_clear_len", 64'(len), 64'(CLR_D));
        check("init_clear_start_ok", 64'(first >= 1 && first <= 2), 64'd1);
        check("init_issue_ready", 64'(issue_ready), 64'd1);
        tick;
        check("init_events_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic drive_op(input int kind, input logic [31:0] pc);
        issue_valid = 1;
        is_ifence = (kind == 0);
        is_sfence = (kind == 1);
        is_ret = (kind == 2);
        pc_p4 = pc;
    endtask

    task automatic sc_op(input int kind);
        logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
        int d = $urandom_range(0, 6);
        int k = $urandom_range(0, 4);
        if (kind == 2) begin
            push(K_RET, 0, 0, 0, 0, 0);
            push(K_PC, epc, 0, 0, 0, 0);
        end else begin
            push(K_PC, pc, 0, 0, 0, 0);
        end
        push(K_SQ, 0, 0, 0, 0, 0);
        if (kind == 1 && SFENCE_EN) push(K_TLB, 0, 0, 0, 0, TLB_D);
        drive_op(kind, pc);
        post_issue_count = (d == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        sq_empty = (d == 0);
        no_released_stores_pending = 0;
        tick;
        issue_valid = 0; is_ifence = 0; is_sfence = 0; is_ret = 0;
        repeat (d) tick;
        post_issue_count = 0; sq_empty = 1;
        repeat (k) tick;
        no_released_stores_pending = 1;
        wait_idle("op");
    endtask

    task automatic drive_exc(input logic [3:0] mask, input logic [IDW-1:0] oldest,
                             input logic [IDW-1:0] ids[NSRC], input logic [4:0] codes[NSRC],
                             input logic [31:0] tvals[NSRC]);
        oldest_id = oldest;
        for (int i = 0; i < NSRC; i++) begin
            exc_id[i*IDW +: IDW] = ids[i];
            exc_code[i*5 +: 5] = codes[i];
            exc_tval[i*32 +: 32] = tvals[i];
        end
        exc_valid = mask;
    endtask

    task automatic push_trap(input logic [3:0] mask, input logic [IDW-1:0] oldest,
                             input logic [IDW-1:0] ids[NSRC], input logic [4:0] codes[NSRC],
                             input logic [31:0] tvals[NSRC]);
        int s = -1;
        for (int i = NSRC - 1; i >= 0; i--)
            if (mask[i] && ids[i] == oldest) s = i;
        push(K_TRAP, 0, 4'(1 << s), codes[s], tvals[s], 0);
        push(K_PC, trap_target_pc, 0, 0, 0, 0);
        push(K_SQ, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_exc(output logic [3:0] mask, output logic [IDW-1:0] oldest,
                            output logic [IDW-1:0] ids[NSRC], output logic [4:0] codes[NSRC],
                            output logic [31:0] tvals[NSRC]);
        int s;
        mask = 4'($urandom_range(1, 15));
        oldest = IDW'($urandom);
        for (int i = 0; i < NSRC; i++) begin
            ids[i] = IDW'($urandom);
            codes[i] = 5'($urandom);
            tvals[i] = $urandom;
        end
        do s = $urandom_range(0, NSRC - 1); while (!mask[s]);
        ids[s] = oldest;
    endtask

    task automatic sc_exc_idle;
        logic [3:0] mask; logic [IDW-1:0] oldest;
        logic [IDW-1:0] ids[NSRC]; logic [4:0] codes[NSRC]; logic [31:0] tvals[NSRC];
        rand_exc(mask, oldest, ids, codes, tvals);
        push_trap(mask, oldest, ids, codes, tvals);
        drive_exc(mask, oldest, ids, codes, tvals);
        tick;
        exc_valid = 0;
        wait_idle("exc_idle");
    endtask

    task automatic sc_exc_vs_op;
        logic [3:0] mask; logic [IDW-1:0] oldest;
        logic [IDW-1:0] ids[NSRC]; logic [4:0] codes[NSRC]; logic [31:0] tvals[NSRC];
        int d = $urandom_range(1, 5);
        rand_exc(mask, oldest, ids, codes, tvals);
        push_trap(mask, oldest, ids, codes, tvals);
        drive_op($urandom_range(0, 2), $urandom & 32'hFFFF_FFFC);
        post_issue_count = 2; sq_empty = 0;
        tick;
        issue_valid = 0; is_ifence = 0; is_sfence = 0; is_ret = 0;
        repeat (d) tick;
        post_issue_count = 0; sq_empty = 1;
        drive_exc(mask, oldest, ids, codes, tvals);
        tick;
        exc_valid = 0;
        wait_idle("exc_vs_op");
    endtask

    task automatic sc_nonoldest;
        logic [3:0] mask = 4'($urandom_range(1, 15));
        logic [IDW-1:0] oldest = IDW'($urandom);
        logic [IDW-1:0] ids[NSRC]; logic [4:0] codes[NSRC]; logic [31:0] tvals[NSRC];
        int r = $urandom_range(1, 5);
        for (int i = 0; i < NSRC; i++) begin
            ids[i] = oldest ^ IDW'($urandom_range(1, 7));
            codes[i] = 5'($urandom);
            tvals[i] = $urandom;
        end
        drive_exc(mask, oldest, ids, codes, tvals);
        repeat (r) tick;
        check("nonoldest_in_drain", 64'({fetch_hold, issue_ready}), 64'b10);
        exc_valid = 0;
        wait_idle("nonoldest");
    endtask

    task automatic sc_int(input bit with_ret);
        int n = 0;
        int d = $urandom_range(1, 5);
        if (with_ret) begin
            push(K_RET, 0, 0, 0, 0, 0);
            push(K_PC, epc, 0, 0, 0, 0);
            push(K_SQ, 0, 0, 0, 0, 0);
            drive_op(2, $urandom & 32'hFFFF_FFFC);
            post_issue_count = 2; sq_empty = 0;
        end
        push(K_INT, 0, 0, 0, 0, 0);
        push(K_PC, trap_target_pc, 0, 0, 0, 0);
        push(K_SQ, 0, 0, 0, 0, 0);
        interrupt_pending = 1;
        tick;
        issue_valid = 0; is_ifence = 0; is_sfence = 0; is_ret = 0;
        if (with_ret) begin
            repeat (d) tick;
            post_issue_count = 0; sq_empty = 1;
        end
        @(negedge clk);
        while (!interrupt_taken && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("interrupt_taken_seen", 64'(n < 200), 64'd1);
        tick;
        interrupt_pending = 0;
        wait_idle(with_ret ? "ret_then_int" : "interrupt");
    endtask

    initial begin
        logic [IDW-1:0] ids[NSRC]; logic [4:0] codes[NSRC]; logic [31:0] tvals[NSRC];
        set_defaults();
        reset_and_init();

        epc = 32'h0000_2000; trap_target_pc = 32'h0000_0100;
        sc_op(0);
        sc_op(1);
        sc_op(2);

        for (int i = 0; i < NSRC; i++) begin
            ids[i] = 3'd1; codes[i] = 5'd0; tvals[i] = 32'hA000_0000 + i;
        end
        ids[1] = 3'd5; ids[3] = 3'd5; codes[1] = 5'd2; codes[3] = 5'd9;
        push_trap(4'b1010, 3'd5, ids, codes, tvals);
        tick;
        drive_exc(4'b1010, 3'd5, ids, codes, tvals);
        tick;
        exc_valid = 0;
        wait_idle("directed_exc");

        sc_int(1'b1);
        sc_nonoldest();

        for (int it = 0; it < 30; it++) begin
            epc = $urandom & 32'hFFFF_FFFC;
            trap_target_pc = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 6))
                0: sc_op(0);
                1: sc_op(1);
                2: sc_op(2);
                3: sc_exc_idle();
                4: sc_exc_vs_op();
                5: sc_nonoldest();
                default: sc_int(1'($urandom));
            endcase
        end

        drive_op(0, 32'h0000_3004);
        post_issue_count = 3; sq_empty = 0;
        tick;
        issue_valid = 0; is_ifence = 0;
        repeat (3) tick;
        reset_and_init();
        sc_op(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/gc_sequencer.md
# gc_sequencer

Parametrised global-control sequencer for the CVA5 pipeline. Accepts any number of exception sources, selects the oldest-instruction exception, and orders pipeline drain, front-end flush, post-issue discard, store-queue flush and TLB invalidation for exceptions, interrupts, FENCE.I, SFENCE.VMA and xRET. It sits beside decode/issue and drives the global hold, flush and PC-override controls.

## Interface
Parameters:
- NUM_SRC, 4: number of exception sources.
- ID_W, 3: instruction ID width.
- CLEAR_DEPTH, 64: cycles `init_clear` is held after reset.
- TLB_DEPTH, 32: cycles `tlb_flush` is held for an SFENCE.
- RESET_VEC, 32'h80000000: PC issued at the end of initialisation.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  GC-class instruction issued this cycle.
- is_ifence, is_sfence, is_ret  in  1 each  op flags, qualified by `issue_valid`; at most one set.
- pc_p4  in  32  issuing instruction PC+4.
- issue_ready  out  1  `state==IDLE & ~op_pending`.
- exc_valid  in  NUM_SRC  per-source exception pending.
- exc_id  in  NUM_SRC*ID_W  per-source instruction ID.
- exc_code  in  NUM_SRC*5  per-source cause.
- exc_tval  in  NUM_SRC*32  per-source tval.
- exc_ack  out  NUM_SRC  one-hot ack of the selected source.
- oldest_id  in  ID_W  ID of the oldest in-flight instruction.
- interrupt_pending  in  1  interrupt request.
- interrupt_taken  out  1  one-cycle pulse.
- trap_target_pc, epc  in  32 each  trap vector and return PC.
- post_issue_count  in  ID_W+1  count of in-flight post-issue instructions.
- sq_empty, no_released_stores_pending  in  1 each  load/store status.
- trap_valid  out  1  selected exception taken (pulse).
- trap_code  out  5  cause of the selected exception.
- trap_tval  out  32  tval of the selected exception.
- ret_taken  out  1  pulse.
- fetch_hold, issue_hold, retire_hold, writeback_supress, init_clear, tlb_flush, sq_flush, pc_override  out  1 each  registered controls.
- pc_out  out  32  registered override PC.

## Operation
- Exception selection: the lowest index i with `exc_valid[i] & exc_id[i]==oldest_id`. `trap_valid` and `exc_ack[i]` assert in the same cycle, only on the cycle the FSM enters FLUSH because of that exception.
- `op_pending` latches the op flags and `pc_p4` on accepted issue and clears on entry to FLUSH.
- States: RESET, INIT_CLEAR, IDLE, DRAIN, FLUSH, DISCARD, TLB_CLEAR.
  - RESET→INIT_CLEAR unconditionally.
  - INIT_CLEAR→IDLE after CLEAR_DEPTH cycles.
  - IDLE: selected exception→FLUSH; else accepted issue, `interrupt_pending` or any `exc_valid`→DRAIN.
  - DRAIN, in priority order: selected exception→FLUSH (trap); else `op_pending & post_issue_count==0 & sq_empty`→FLUSH (op); else `interrupt_pending & ~op_pending`→FLUSH (interrupt, `interrupt_taken` pulse); else `~op_pending & ~interrupt_pending & ~|exc_valid`→IDLE.
  - FLUSH→DISCARD unconditionally.
  - DISCARD: when `post_issue_count==0 & no_released_stores_pending`, go to TLB_CLEAR if the cause was SFENCE, else IDLE.
  - TLB_CLEAR→IDLE after TLB_DEPTH cycles.
- `pc_out` is loaded on entry to FLUSH. Selection: trap or interrupt→`trap_target_pc`; ifence/sfence→latched `pc_p4`; ret→`epc` with a `ret_taken` pulse. On INIT_CLEAR→IDLE, `pc_out` loads RESET_VEC.
- Registered controls, each a function of next_state:
  - fetch_hold in {INIT_CLEAR, DRAIN, FLUSH}.
  - issue_hold in {INIT_CLEAR, DRAIN, FLUSH, DISCARD, TLB_CLEAR}.
  - writeback_supress in {INIT_CLEAR, DISCARD}.
  - retire_hold in {FLUSH}.
  - init_clear in {INIT_CLEAR}.
  - tlb_flush in {INIT_CLEAR, TLB_CLEAR}.
  - pc_override on next_state==FLUSH or on INIT_CLEAR→IDLE.
  - sq_flush on DISCARD→exit.
- The state counter has width clog2(max(CLEAR_DEPTH,TLB_DEPTH))+1. It clears on IDLE and increments in INIT_CLEAR and TLB_CLEAR.

## Timing
- While `rst` is high: state=RESET and every registered output is 0. `issue_ready`, `exc_ack`, `trap_valid`, `interrupt_taken` and `ret_taken` are 0.
- Controls are valid one cycle after the state decision.
- `init_clear` is high for exactly CLEAR_DEPTH cycles, starting 2 cycles after `rst` falls.
- Minimum trap latency from IDLE: exception visible at cycle N, `pc_override` high at N+1 for one cycle.
- Simultaneous exception and op completion in DRAIN: the exception wins, and `op_pending` is discarded.
- Reset mid-sequence aborts it and restarts initialisation.

## Configuration
- GC_SFENCE_EN defined: the SFENCE path, TLB_CLEAR state and `tlb_flush` are present.
- Undefined: `is_sfence` behaves as `is_ifence`, TLB_CLEAR is unreachable, and `tlb_flush` is tied to 0 (including during INIT_CLEAR).

## Test plan
- Reset held 3 cycles, released → `init_clear` high 64 cycles; then `pc_override`=1 with `pc_out`=32'h80000000; then `issue_ready`=1.
- FENCE.I with pc_p4=0x1004 and `post_issue_count`=2 falling to 0 after 5 cycles → DRAIN held; `pc_out`=0x1004; `sq_flush` pulses on DISCARD exit.
- Sources 1 and 3 both valid with `exc_id`=oldest_id=5, code 2 → `exc_ack`=4'b0010, `trap_code`=2, `pc_out`=`trap_target_pc`.
- `interrupt_pending` with an MRET pending, not yet drained → MRET completes first with `ret_taken`=1, `pc_out`=`epc`, and no `interrupt_taken` that cycle.
- SFENCE (GC_SFENCE_EN defined) → `tlb_flush` high 32 cycles after DISCARD. With the macro undefined, `tlb_flush` stays 0.
- `exc_valid` for a non-oldest ID that drops while in DRAIN → FSM returns to IDLE and `pc_override` never asserts.
